tlp_rx_memwr_axi_master: RTL and testbench
==========================================

Name: tlp_rx_memwr_axi_master

Overview:
Receive-side counterpart of the AXI-write-to-MemWr TLP generator. It accepts one complete MemWr TLP per handshake, as a header plus a packed payload. It validates the header and replays the TLP as a single AXI4 INCR write burst (AW, then W beats, then B). Malformed or non-MemWr TLPs are dropped and counted. It sits between the PCIe RX TLP path and the on-chip AXI interconnect.

Parameters:
ID_WIDTH, 4, AXI ID width
ADDR_WIDTH, 32, AXI address width
DATA_WIDTH, 256, AXI data width in bits (multiple of 32)
CHUNK_MAX_BEATS, 4, maximum payload beats per TLP
AXI_ID, 0, constant driven on awid_out

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
tlp_valid_in  in  1  TLP offered
tlp_ready_out  out  1  TLP accepted when valid && ready
tlp_hdr_in  in  $bits(tlp_memory_req_header)  header (PCIE_PKG); fields used: fmt, type, length (DW), requester_id, addr
tlp_payload_in  in  DATA_WIDTH*CHUNK_MAX_BEATS  payload; beat 0 in MSBs
awvalid_out  out  1  AXI AW valid
awready_in  in  1  AXI AW ready
awid_out  out  ID_WIDTH  = AXI_ID
awaddr_out  out  ADDR_WIDTH  write address
awlen_out  out  8  beats-1
awsize_out  out  3  log2(DATA_WIDTH/8)
awburst_out  out  2  2'b01 INCR
wvalid_out  out  1  AXI W valid
wready_in  in  1  AXI W ready
wdata_out  out  DATA_WIDTH  beat data
wstrb_out  out  DATA_WIDTH/8  byte strobes
wlast_out  out  1  last beat
bvalid_in  in  1  AXI B valid
bready_out  out  1  AXI B ready
bresp_in  in  2  AXI write response
wr_done_out  out  1  one-cycle pulse when B accepted
last_bdf_out  out  16  requester_id of last completed write
drop_cnt_out  out  16  saturating count of dropped TLPs
err_cnt_out  out  16  saturating count of bresp != OKAY

Behaviour:
- Reset: state IDLE. All valid/ready outputs 0 except tlp_ready_out=1. Counters, last_bdf_out and data/address regs 0. Reset mid-burst abandons the burst immediately; awvalid/wvalid deassert asynchronously.
- FSM states: IDLE, AW, W, B.
- IDLE: tlp_ready_out=1. On accept, latch header and payload and decode in the same cycle.
  - Legal: fmt/type = MemWr (3DW or 4DW), length != 0, beats <= CHUNK_MAX_BEATS.
  - beats = ceil(length*4 / (DATA_WIDTH/8)); the length field is 10 bits, and 0 is illegal (not 1024).
  - Legal TLP -> AW next cycle. Illegal TLP -> drop_cnt++ (saturate at 16'hFFFF), stay IDLE. No AXI activity for a dropped TLP.
- AW: awvalid_out=1, awaddr_out = latched addr[ADDR_WIDTH-1:0], awlen_out = beats-1. Hold all AW fields stable until awready_in; then go to W. awvalid_out=1 on the first cycle after accept.
- W: wvalid_out=1, with a beat counter starting at 0. wdata_out = payload slice for the current beat (beat i = bits [DATA_WIDTH*(CHUNK_MAX_BEATS-i)-1 -: DATA_WIDTH]).
  - wstrb_out is all-ones, except on the last beat when (length*4) mod (DATA_WIDTH/8) != 0: then only the lower (length*4 mod DATA_WIDTH/8) bytes are set.
  - wlast_out=1 on beat beats-1.
  - Each wvalid&&wready advances the counter; data is held while ready is low. Last beat accepted -> B.
- B: bready_out=1. On bvalid_in: wr_done_out pulses for 1 cycle and last_bdf_out <= requester_id. If bresp_in != 2'b00, err_cnt++ (saturating). Return to IDLE; the next TLP can be accepted in the cycle after B completes.
- W never starts before AW completes; B is never accepted before wlast.
- tlp_ready_out is 0 in AW/W/B, so there is only one outstanding write.
- AW, W and B channel stalls of any length are tolerated with no data loss or field change.

Decomposition:
- PCIE_PKG: tlp_memory_req_header, fmt/type MemWr constants, AXI_BURST_INCR, AXI_RESP_OKAY, and function tlp_len_to_beats(length, bytes_per_beat).
- One sub-module, axi_wstrb_gen: combinational last-beat strobe from length and beat index.
- FSM, counters and payload slicing stay in the top module.

Test Plan:
- MemWr, addr 32'h0000_1000, length 32 DW, req 16'h0002 -> AW awaddr 0x1000, awlen 3, awsize 5, awburst 01. Then 4 W beats with beat 0 = payload MSBs, full strobes, wlast on beat 3. bresp OKAY -> wr_done pulse and last_bdf 0x0002.
- length 5 DW -> awlen 0, single beat, wstrb 32'h000F_FFFF, wlast=1.
- length 40 DW, or a MemRd type, or length 0 -> no AXI activity, drop_cnt increments per TLP, tlp_ready_out stays 1.
- Random awready/wready stalls of 0-7 cycles over 20 TLPs -> AXI-side scoreboard matches all addr/data/strobe values; no beat duplicated or lost.
- bresp 2'b10 -> err_cnt=1 and wr_done still pulses. Back-to-back TLP held valid -> accepted on the first IDLE cycle after B.
- rst_n asserted during beat 2 of 4 -> all valids 0 immediately and counters 0. A new TLP after reset produces a clean burst.

Source files
------------

// File: rtl/tlp_rx_memwr_axi_master_pkg.sv
// Shared PCIe/AXI definitions for the MemWr TLP receive path.
// Contents: memory request header layout, MemWr fmt/type codes, AXI burst and
// response codes, the write-FSM state type and a DW-length to beat-count helper.
package tlp_rx_memwr_axi_master_pkg;

    typedef struct packed {
        logic [2:0]  fmt;
        logic [4:0]  tlp_type;
        logic [2:0]  tc;
        logic [2:0]  attr;
        logic        td;
        logic        ep;
        logic [9:0]  length;
        logic [15:0] requester_id;
        logic [7:0]  tag;
        logic [3:0]  last_be;
        logic [3:0]  first_be;
        logic [63:0] addr;
    } tlp_memory_req_header;

    localparam logic [2:0] TLP_FMT_3DW_DATA = 3'b010;
    localparam logic [2:0] TLP_FMT_4DW_DATA = 3'b011;
    localparam logic [4:0] TLP_TYPE_MEM     = 5'b00000;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    typedef enum logic [1:0] {ST_IDLE, ST_AW, ST_W, ST_B} wr_state_t;

    // Number of bus beats needed to carry length DWs; length 0 yields 0 beats
    // so the caller can reject it rather than treating it as 1024 DW.
    function automatic logic [10:0] tlp_len_to_beats(input logic [9:0]  length,
                                                     input int unsigned bytes_per_beat);
        int unsigned num_bytes;
        num_bytes = {20'd0, length, 2'b00};
        return 11'((num_bytes + bytes_per_beat - 1) / bytes_per_beat);
    endfunction

endpackage

// File: rtl/tlp_rx_memwr_axi_master_wstrb.sv
// axi_wstrb_gen: combinational W strobe for one beat of a burst.
// Ports:
//   length   - TLP length in DW (1..1023)
//   beat_idx - index of the beat currently presented
//   wstrb    - all ones, except a partial last beat keeps only its low bytes
module axi_wstrb_gen
    import tlp_rx_memwr_axi_master_pkg::*;
#(
    parameter int DATA_WIDTH = 256,
    parameter int BEAT_W     = 2
) (
    input  logic [9:0]              length,
    input  logic [BEAT_W-1:0]       beat_idx,
    output logic [DATA_WIDTH/8-1:0] wstrb
);
    localparam int unsigned STRB_W = DATA_WIDTH / 8;

    logic [10:0] beats;
    logic        partial_last;
    int unsigned rem_bytes;

    always_comb begin
        beats        = tlp_len_to_beats(length, STRB_W);
        rem_bytes    = {20'd0, length, 2'b00} % STRB_W;
        partial_last = (11'(beat_idx) == beats - 11'd1) && (rem_bytes != 0);
        for (int unsigned i = 0; i < STRB_W; i++) begin
            wstrb[i] = !partial_last || (i < rem_bytes);
        end
    end

endmodule

// File: rtl/tlp_rx_memwr_axi_master.sv
// tlp_rx_memwr_axi_master: replays one received MemWr TLP as one AXI4 INCR
// write burst (AW, W beats, B). Anything that is not a well-formed MemWr that
// fits in CHUNK_MAX_BEATS beats is dropped and counted. One write outstanding.
// Ports:
//   clk, rst_n          - clock, async active-low reset
//   tlp_*               - TLP input handshake, header, packed payload (beat 0 in MSBs)
//   aw*/w*/b*           - AXI4 write master channels
//   wr_done_out         - one-cycle pulse after the B handshake
//   last_bdf_out        - requester_id of the most recently completed write
//   drop_cnt_out        - saturating count of dropped TLPs
//   err_cnt_out         - saturating count of non-OKAY write responses
//
// state   | meaning
// ST_IDLE | ready for a TLP; decode and latch on accept
// ST_AW   | presenting the write address
// ST_W    | streaming payload beats
// ST_B    | waiting for the write response
module tlp_rx_memwr_axi_master
    import tlp_rx_memwr_axi_master_pkg::*;
#(
    parameter int ID_WIDTH        = 4,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 256,
    parameter int CHUNK_MAX_BEATS = 4,
    parameter int AXI_ID          = 0
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  tlp_valid_in,
    output logic                                  tlp_ready_out,
    input  tlp_memory_req_header                  tlp_hdr_in,
    input  logic [DATA_WIDTH*CHUNK_MAX_BEATS-1:0] tlp_payload_in,
    output logic                                  awvalid_out,
    input  logic                                  awready_in,
    output logic [ID_WIDTH-1:0]                   awid_out,
    output logic [ADDR_WIDTH-1:0]                 awaddr_out,
    output logic [7:0]                            awlen_out,
    output logic [2:0]                            awsize_out,
    output logic [1:0]                            awburst_out,
    output logic                                  wvalid_out,
    input  logic                                  wready_in,
    output logic [DATA_WIDTH-1:0]                 wdata_out,
    output logic [DATA_WIDTH/8-1:0]               wstrb_out,
    output logic                                  wlast_out,
    input  logic                                  bvalid_in,
    output logic                                  bready_out,
    input  logic [1:0]                            bresp_in,
    output logic                                  wr_done_out,
    output logic [15:0]                           last_bdf_out,
    output logic [15:0]                           drop_cnt_out,
    output logic [15:0]                           err_cnt_out
);
    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int BEAT_W = (CHUNK_MAX_BEATS > 1) ? $clog2(CHUNK_MAX_BEATS) : 1;
    localparam int PAY_W  = DATA_WIDTH * CHUNK_MAX_BEATS;

    wr_state_t state, state_nxt;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [9:0]            len_q;
    logic [15:0]           req_id_q;
    logic [PAY_W-1:0]      payload_q;
    logic [7:0]            awlen_q;
    logic [BEAT_W-1:0]     beat_q;
    logic                  wr_done_q;
    logic [15:0]           last_bdf_q;
    logic [15:0]           drop_cnt_q;
    logic [15:0]           err_cnt_q;

    logic [10:0] beats_in;
    logic        hdr_legal;
    logic        tlp_accept;
    logic        last_beat;
    logic        unused_hdr;

    // Only a few header fields matter here; fold the rest into a sink.
    assign unused_hdr = ^tlp_hdr_in;

    always_comb begin
        beats_in  = tlp_len_to_beats(tlp_hdr_in.length, STRB_W);
        hdr_legal = ((tlp_hdr_in.fmt == TLP_FMT_3DW_DATA) || (tlp_hdr_in.fmt == TLP_FMT_4DW_DATA))
                    && (tlp_hdr_in.tlp_type == TLP_TYPE_MEM)
                    && (tlp_hdr_in.length != 10'd0)
                    && (beats_in <= 11'(CHUNK_MAX_BEATS));
    end

    assign tlp_accept = (state == ST_IDLE) && tlp_valid_in;
    assign last_beat  = (8'(beat_q) == awlen_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        tlp_ready_out = 1'b0;
        awvalid_out   = 1'b0;
        wvalid_out    = 1'b0;
        wlast_out     = 1'b0;
        bready_out    = 1'b0;
        case (state)
            ST_IDLE: begin
                tlp_ready_out = 1'b1;
                if (tlp_valid_in && hdr_legal) state_nxt = ST_AW;
            end
            ST_AW: begin
                awvalid_out = 1'b1;
                if (awready_in) state_nxt = ST_W;
            end
            ST_W: begin
                wvalid_out = 1'b1;
                wlast_out  = last_beat;
                if (wready_in && last_beat) state_nxt = ST_B;
            end
            ST_B: begin
                bready_out = 1'b1;
                if (bvalid_in) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= '0;
            len_q      <= '0;
            req_id_q   <= '0;
            payload_q  <= '0;
            awlen_q    <= '0;
            beat_q     <= '0;
            wr_done_q  <= 1'b0;
            last_bdf_q <= '0;
            drop_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            wr_done_q <= 1'b0;
            if (tlp_accept) begin
                beat_q <= '0;
                if (hdr_legal) begin
                    addr_q    <= tlp_hdr_in.addr[ADDR_WIDTH-1:0];
                    len_q     <= tlp_hdr_in.length;
                    req_id_q  <= tlp_hdr_in.requester_id;
                    payload_q <= tlp_payload_in;
                    awlen_q   <= 8'(beats_in - 11'd1);
                end else if (drop_cnt_q != 16'hFFFF) begin
                    drop_cnt_q <= drop_cnt_q + 16'd1;
                end
            end
            if (wvalid_out && wready_in) beat_q <= beat_q + BEAT_W'(1);
            if (bready_out && bvalid_in) begin
                wr_done_q  <= 1'b1;
                last_bdf_q <= req_id_q;
                if ((bresp_in != AXI_RESP_OKAY) && (err_cnt_q != 16'hFFFF))
                    err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end

    // Beat 0 occupies the payload MSBs.
    always_comb begin
        wdata_out = '0;
        for (int i = 0; i < CHUNK_MAX_BEATS; i++) begin
            if (beat_q == BEAT_W'(i))
                wdata_out = payload_q[PAY_W-1-i*DATA_WIDTH -: DATA_WIDTH];
        end
    end

    axi_wstrb_gen #(
        .DATA_WIDTH (DATA_WIDTH),
        .BEAT_W     (BEAT_W)
    ) u_wstrb (
        .length   (len_q),
        .beat_idx (beat_q),
        .wstrb    (wstrb_out)
    );

    assign awid_out     = ID_WIDTH'(AXI_ID);
    assign awaddr_out   = addr_q;
    assign awlen_out    = awlen_q;
    assign awsize_out   = 3'($clog2(STRB_W));
    assign awburst_out  = AXI_BURST_INCR;
    assign wr_done_out  = wr_done_q;
    assign last_bdf_out = last_bdf_q;
    assign drop_cnt_out = drop_cnt_q;
    assign err_cnt_out  = err_cnt_q;

endmodule

// File: tb/tb_tlp_rx_memwr_axi_master.sv
module tb_tlp_rx_memwr_axi_master;
    import tlp_rx_memwr_axi_master_pkg::*;

    localparam int DW  = 256;
    localparam int CMB = 4;
    localparam int SW  = DW / 8;
    localparam int PW  = DW * CMB;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 tlp_valid_in = 1'b0;
    logic                 tlp_ready_out;
    tlp_memory_req_header tlp_hdr_in = '0;
    logic [PW-1:0]        tlp_payload_in = '0;
    logic                 awvalid_out;
    logic                 awready_in = 1'b0;
    logic [3:0]           awid_out;
    logic [31:0]          awaddr_out;
    logic [7:0]           awlen_out;
    logic [2:0]           awsize_out;
    logic [1:0]           awburst_out;
    logic                 wvalid_out;
    logic                 wready_in = 1'b0;
    logic [DW-1:0]        wdata_out;
    logic [SW-1:0]        wstrb_out;
    logic                 wlast_out;
    logic                 bvalid_in = 1'b0;
    logic                 bready_out;
    logic [1:0]           bresp_in = 2'b00;
    logic                 wr_done_out;
    logic [15:0]          last_bdf_out;
    logic [15:0]          drop_cnt_out;
    logic [15:0]          err_cnt_out;

    tlp_rx_memwr_axi_master dut (
        .clk(clk), .rst_n(rst_n),
        .tlp_valid_in(tlp_valid_in), .tlp_ready_out(tlp_ready_out),
        .tlp_hdr_in(tlp_hdr_in), .tlp_payload_in(tlp_payload_in),
        .awvalid_out(awvalid_out), .awready_in(awready_in), .awid_out(awid_out),
        .awaddr_out(awaddr_out), .awlen_out(awlen_out), .awsize_out(awsize_out),
        .awburst_out(awburst_out),
        .wvalid_out(wvalid_out), .wready_in(wready_in), .wdata_out(wdata_out),
        .wstrb_out(wstrb_out), .wlast_out(wlast_out),
        .bvalid_in(bvalid_in), .bready_out(bready_out), .bresp_in(bresp_in),
        .wr_done_out(wr_done_out), .last_bdf_out(last_bdf_out),
        .drop_cnt_out(drop_cnt_out), .err_cnt_out(err_cnt_out)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: phase 0 idle, 1 address, 2 data, 3 response.
    int            phase = 0;
    logic [31:0]   cur_addr;
    int            cur_len, cur_beats, w_idx;
    logic [15:0]   cur_bdf;
    logic [PW-1:0] cur_pay;
    bit            done_exp = 0;
    logic [15:0]   exp_bdf = 0;
    int            exp_drop = 0, exp_err = 0;

    int            cyc = 0, acc_cyc = 0, bfire_cyc = 0;
    bit            accepted = 0;
    int            stall_max = 0, force_bresp = 0;
    int            aw_cnt = 0, w_cnt = 0, b_cnt = 0;

    logic [31:0]   obs_awaddr;
    logic [7:0]    obs_awlen;
    logic [SW-1:0] obs_last_strb;
    logic [DW-1:0] obs_beat0;
    int            obs_beats;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int m_beats(input int len);
        return (len * 4 + SW - 1) / SW;
    endfunction

    function automatic logic [SW-1:0] m_strb(input int len, input int i);
        int          rem;
        logic [SW-1:0] one;
        rem = (len * 4) % SW;
        one = 1;
        if (i == m_beats(len) - 1 && rem != 0) return (one << rem) - 1;
        return '1;
    endfunction

    function automatic logic [DW-1:0] m_data(input logic [PW-1:0] pay, input int i);
        logic [PW-1:0] t;
        t = pay >> (DW * (CMB - 1 - i));
        return t[DW-1:0];
    endfunction

    // One clock: apply the handshakes seen at the preceding posedge to the
    // model, compare every output, then drive the next cycle's inputs.
    task automatic step();
        bit aw_f, w_f, b_f, last_w;
        @(negedge clk);
        cyc++;
        if (!rst_n) return;
        aw_f = (phase == 1) && awready_in;
        w_f  = (phase == 2) && wready_in;
        b_f  = (phase == 3) && bvalid_in;
        last_w = 0;
        done_exp = 0;
        if (phase == 0 && tlp_valid_in) begin
            accepted = 1;
            acc_cyc  = cyc;
            if ((tlp_hdr_in.fmt == 3'b010 || tlp_hdr_in.fmt == 3'b011) && tlp_hdr_in.tlp_type == 5'd0
                && tlp_hdr_in.length != 0 && m_beats(int'(tlp_hdr_in.length)) <= CMB) begin
                cur_addr  = tlp_hdr_in.addr[31:0];
                cur_len   = int'(tlp_hdr_in.length);
                cur_beats = m_beats(cur_len);
                cur_bdf   = tlp_hdr_in.requester_id;
                cur_pay   = tlp_payload_in;
                phase     = 1;
            end else if (exp_drop < 65535) begin
                exp_drop++;
            end
        end else if (aw_f) begin
            phase = 2; w_idx = 0; obs_beats = 0;
        end else if (w_f) begin
            obs_beats++;
            if (w_idx == cur_beats - 1) begin phase = 3; last_w = 1; end
            else w_idx++;
        end else if (b_f) begin
            done_exp  = 1;
            exp_bdf   = cur_bdf;
            if (bresp_in != 2'b00 && exp_err < 65535) exp_err++;
            phase     = 0;
            bfire_cyc = cyc;
        end

        chk("tlp_ready", tlp_ready_out, phase == 0);
        chk("awvalid", awvalid_out, phase == 1);
        if (phase == 1) begin
            chk("awaddr", awaddr_out, cur_addr);
            chk("awlen", awlen_out, 8'(cur_beats - 1));
            chk("awsize", awsize_out, 3'd5);
            chk("awburst", awburst_out, 2'b01);
            chk("awid", awid_out, 4'd0);
            obs_awaddr = awaddr_out;
            obs_awlen  = awlen_out;
        end
        chk("wvalid", wvalid_out, phase == 2);
        if (phase == 2) begin
            chk("wdata", wdata_out, m_data(cur_pay, w_idx));
            chk("wstrb", wstrb_out, m_strb(cur_len, w_idx));
            chk("wlast", wlast_out, w_idx == cur_beats - 1);
            if (w_idx == 0) obs_beat0 = wdata_out;
            if (w_idx == cur_beats - 1) obs_last_strb = wstrb_out;
        end
        chk("bready", bready_out, phase == 3);
        chk("wr_done", wr_done_out, done_exp);
        chk("last_bdf", last_bdf_out, exp_bdf);
        chk("drop_cnt", drop_cnt_out, 16'(exp_drop));
        chk("err_cnt", err_cnt_out, 16'(exp_err));

        if (accepted && acc_cyc == cyc) tlp_valid_in = 1'b0;
        if (aw_f) aw_cnt = $urandom_range(0, stall_max);
        else if (phase == 1 && aw_cnt > 0) aw_cnt--;
        awready_in = (aw_cnt == 0);
        if (w_f) w_cnt = $urandom_range(0, stall_max);
        else if (phase == 2 && w_cnt > 0) w_cnt--;
        wready_in = (w_cnt == 0);
        if (last_w) begin
            if (force_bresp >= 0) bresp_in = 2'(force_bresp);
            else bresp_in = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00;
        end
        if (b_f) begin
            b_cnt = $urandom_range(0, stall_max);
            bvalid_in = 1'b0;
        end else if (phase == 3) begin
            if (b_cnt > 0) b_cnt--;
            bvalid_in = (b_cnt == 0);
        end else begin
            bvalid_in = 1'b0;
        end
    endtask

    task automatic send_tlp(input logic [2:0] fmt, input logic [4:0] typ, input int len,
                            input logic [31:0] addr, input logic [15:0] bdf, input logic [PW-1:0] pay);
        tlp_memory_req_header h;
        h = '0;
        h.fmt = fmt; h.tlp_type = typ; h.length = 10'(len);
        h.requester_id = bdf; h.addr = {32'h0, addr};
        tlp_hdr_in = h;
        tlp_payload_in = pay;
        tlp_valid_in = 1'b1;
        accepted = 0;
        for (int k = 0; k < 400 && !accepted; k++) step();
        if (!accepted) begin
            n_chk++; n_err++;
            $display("FAIL tlp_accept_timeout: got not-accepted expected accepted (cycle %0d)", cyc);
            tlp_valid_in = 1'b0;
        end
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 400 && phase != 0; k++) step();
        n_chk++;
        if (phase != 0) begin
            n_err++;
            $display("FAIL burst_timeout: got phase %0d expected 0 (cycle %0d)", phase, cyc);
        end
        step();
    endtask

    function automatic logic [PW-1:0] rand_pay();
        logic [PW-1:0] p;
        for (int i = 0; i < PW / 32; i++) p[i*32 +: 32] = $urandom;
        return p;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [PW-1:0] pay;
        int len;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("rst_tlp_ready", tlp_ready_out, 1'b1);
        chk("rst_awvalid", awvalid_out, 1'b0);
        chk("rst_drop", drop_cnt_out, 16'h0);

        // Four-beat write with full strobes.
        pay = rand_pay();
        send_tlp(3'b010, 5'd0, 32, 32'h0000_1000, 16'h0002, pay);
        wait_idle();
        chk("t1_awaddr", obs_awaddr, 32'h0000_1000);
        chk("t1_awlen", obs_awlen, 8'd3);
        chk("t1_beats", 32'(obs_beats), 32'd4);
        chk("t1_beat0", obs_beat0, pay[PW-1 -: DW]);
        chk("t1_last_strb", obs_last_strb, 32'hFFFF_FFFF);
        chk("t1_last_bdf", last_bdf_out, 16'h0002);

        // Single partial beat.
        send_tlp(3'b011, 5'd0, 5, 32'h0000_2000, 16'h0005, rand_pay());
        wait_idle();
        chk("t2_awlen", obs_awlen, 8'd0);
        chk("t2_beats", 32'(obs_beats), 32'd1);
        chk("t2_last_strb", obs_last_strb, 32'h000F_FFFF);

        // Dropped TLPs: too long, MemRd, zero length.
        send_tlp(3'b010, 5'd0, 40, 32'h0000_3000, 16'h0007, rand_pay());
        step();
        chk("t3_drop1", drop_cnt_out, 16'd1);
        send_tlp(3'b000, 5'd0, 4, 32'h0000_3000, 16'h0007, rand_pay());
        step();
        chk("t3_drop2", drop_cnt_out, 16'd2);
        send_tlp(3'b010, 5'd0, 0, 32'h0000_3000, 16'h0007, rand_pay());
        step();
        chk("t3_drop3", drop_cnt_out, 16'd3);

        // SLVERR response followed by a back-to-back TLP.
        force_bresp = 2;
        send_tlp(3'b010, 5'd0, 8, 32'h0000_4000, 16'h0011, rand_pay());
        send_tlp(3'b010, 5'd0, 16, 32'h0000_5000, 16'h0012, rand_pay());
        force_bresp = 0;
        chk("t4_b2b_gap", 32'(acc_cyc - bfire_cyc), 32'd1);
        chk("t4_err_cnt", err_cnt_out, 16'd1);
        wait_idle();
        chk("t4_last_bdf", last_bdf_out, 16'h0012);

        // Randomized traffic with channel stalls.
        stall_max = 7;
        force_bresp = -1;
        for (int t = 0; t < 20; t++) begin
            len = $urandom_range(1, 32);
            if ($urandom_range(0, 5) == 0)
                send_tlp(3'b010, 5'd0, $urandom_range(33, 60), $urandom, 16'($urandom), rand_pay());
            else
                send_tlp(($urandom_range(0, 1) == 0) ? 3'b010 : 3'b011, 5'd0, len,
                         $urandom, 16'($urandom), rand_pay());
        end
        wait_idle();

        // Reset during beat 2 of 4.
        stall_max = 0;
        force_bresp = 0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        send_tlp(3'b010, 5'd0, 32, 32'h0000_6000, 16'h0021, rand_pay());
        for (int k = 0; k < 100 && !(phase == 2 && w_idx == 2); k++) step();
        chk("t6_at_beat2", phase == 2 && w_idx == 2, 1'b1);
        #2 rst_n = 1'b0;
        awready_in = 1'b0; wready_in = 1'b0; bvalid_in = 1'b0; tlp_valid_in = 1'b0;
        #1;
        chk("t6_awvalid", awvalid_out, 1'b0);
        chk("t6_wvalid", wvalid_out, 1'b0);
        chk("t6_bready", bready_out, 1'b0);
        chk("t6_tlp_ready", tlp_ready_out, 1'b1);
        chk("t6_drop", drop_cnt_out, 16'd0);
        chk("t6_err", err_cnt_out, 16'd0);
        chk("t6_bdf", last_bdf_out, 16'd0);
        chk("t6_awaddr", awaddr_out, 32'd0);
        phase = 0; exp_drop = 0; exp_err = 0; exp_bdf = 0; done_exp = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send_tlp(3'b010, 5'd0, 12, 32'h0000_7000, 16'h0033, rand_pay());
        wait_idle();
        chk("t6_post_awlen", obs_awlen, 8'd1);
        chk("t6_post_strb", obs_last_strb, 32'h0000_FFFF);
        chk("t6_post_bdf", last_bdf_out, 16'h0033);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
